// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample type, loader state encoding and 3-bit bit reversal
// for the fft8 input stage.
package fft_pkg;

    localparam int DATA_W = 32;
    localparam int N      = 8;
    localparam int LOG2N  = 3;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, DONE} state_t;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] a);
        return {a[0], a[1], a[2]};
    endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// fft_sample_ram: 8-entry complex register file, one synchronous write port and two
// combinational read ports; contents are not reset.
module fft_sample_ram
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [LOG2N-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wre_i,
    input  logic [DATA_W-1:0] wim_i,
    input  logic [LOG2N-1:0]  raddr0_i,
    input  logic [LOG2N-1:0]  raddr1_i,
    output logic [DATA_W-1:0] rre0_o,
    output logic [DATA_W-1:0] rim0_o,
    output logic [DATA_W-1:0] rre1_o,
    output logic [DATA_W-1:0] rim1_o
);

    logic [DATA_W-1:0] mem_re [N];
    logic [DATA_W-1:0] mem_im [N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_re[waddr_i] <= wre_i;
            mem_im[waddr_i] <= wim_i;
        end
    end

    assign rre0_o = mem_re[raddr0_i];
    assign rim0_o = mem_im[raddr0_i];
    assign rre1_o = mem_re[raddr1_i];
    assign rim1_o = mem_im[raddr1_i];

endmodule

// File: rtl/fft8_bitrev_loader.sv
// fft8_bitrev_loader: collects an 8-sample frame in bit-reversed order and issues the four
// first-stage butterfly pairs to fft8. Optional watchdog: FFT_LOADER_TIMEOUT_EN.
module fft8_bitrev_loader #(
    parameter int DATA_W         = fft_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              bf_start,
    input  logic              bf_done,
    output logic [DATA_W-1:0] bf_x0_re,
    output logic [DATA_W-1:0] bf_x0_im,
    output logic [DATA_W-1:0] bf_x1_re,
    output logic [DATA_W-1:0] bf_x1_im,
    output logic [1:0]        pair_idx,
    output logic              busy,
`ifdef FFT_LOADER_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              frame_done
);
    import fft_pkg::*;

    state_t            state_q, state_d;
    logic [LOG2N-1:0]  wcnt_q, wcnt_d;
    logic [1:0]        pair_q, pair_d;
    logic              ready_q, wr_en;
    logic [DATA_W-1:0] rd0_re, rd0_im, rd1_re, rd1_im;
    logic [DATA_W-1:0] x0_re_q, x0_im_q, x1_re_q, x1_im_q;

    assign wr_en = (state_q == FILL) && in_valid && ready_q;

    // Read ports follow the next pair index so operands can be registered on entry to ISSUE.
    fft_sample_ram #(.DATA_W(DATA_W)) u_ram (
        .clk      (clk),
        .we_i     (wr_en),
        .waddr_i  (bitrev3(wcnt_q)),
        .wre_i    (in_re),
        .wim_i    (in_im),
        .raddr0_i ({pair_d, 1'b0}),
        .raddr1_i ({pair_d, 1'b1}),
        .rre0_o   (rd0_re),
        .rim0_o   (rd0_im),
        .rre1_o   (rd1_re),
        .rim1_o   (rd1_im)
    );

`ifdef FFT_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pair_d  = pair_q;
`ifdef FFT_LOADER_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            FILL: begin
                if (wr_en) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LOG2N'(N - 1)) state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef FFT_LOADER_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end
            WAIT: begin
                if (bf_done) begin
                    if (pair_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        pair_d  = pair_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
`ifdef FFT_LOADER_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = FILL;
                    pair_d  = '0;
                    wcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = FILL;
                pair_d  = '0;
                wcnt_d  = '0;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            pair_q  <= '0;
            ready_q <= 1'b0;
            x0_re_q <= '0;
            x0_im_q <= '0;
            x1_re_q <= '0;
            x1_im_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pair_q  <= pair_d;
            ready_q <= (state_d == FILL);
            if (state_d == ISSUE) begin
                x0_re_q <= rd0_re;
                x0_im_q <= rd0_im;
                x1_re_q <= rd1_re;
                x1_im_q <= rd1_im;
            end
        end
    end

    assign in_ready   = ready_q;
    assign bf_start   = (state_q == ISSUE);
    assign busy       = (state_q != FILL);
    assign frame_done = (state_q == DONE);
    assign pair_idx   = pair_q;
    assign bf_x0_re   = x0_re_q;
    assign bf_x0_im   = x0_im_q;
    assign bf_x1_re   = x1_re_q;
    assign bf_x1_im   = x1_im_q;

endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// tb_fft8_bitrev_loader: random and directed frames checked against a bit-reversal
// reference model with a scripted butterfly responder.
module tb_fft8_bitrev_loader;
    import fft_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, bf_done = 1'b0;
    logic [31:0] in_re = '0, in_im = '0;
    logic        in_ready, bf_start, busy, frame_done;
    logic [31:0] bf_x0_re, bf_x0_im, bf_x1_re, bf_x1_im;
    logic [1:0]  pair_idx;
`ifdef FFT_LOADER_TIMEOUT_EN
    logic        timeout_err;
`endif

    fft8_bitrev_loader #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .bf_start    (bf_start),
        .bf_done     (bf_done),
        .bf_x0_re    (bf_x0_re),
        .bf_x0_im    (bf_x0_im),
        .bf_x1_re    (bf_x1_re),
        .bf_x1_im    (bf_x1_im),
        .pair_idx    (pair_idx),
        .busy        (busy),
`ifdef FFT_LOADER_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0;
    cplx_t       smp [8];
    int          lat [4], dur [4];
    int          carry = 0;
    bit          hold_v = 1'b0, use_tab = 1'b0;
    logic [31:0] tab0 [4], tab1 [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Arrival index j lands at address rev(j); rev is its own inverse.
    function automatic int rev3(input int v);
        return (v % 2) * 4 + ((v / 2) % 2) * 2 + v / 4;
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 8; i++) begin
            smp[i].re = $urandom;
            smp[i].im = $urandom;
        end
    endtask

    task automatic send(input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_re = $urandom;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_re = smp[i].re;
            in_im = smp[i].im;
            for (int w = 0; w < 32 && !in_ready; w++) @(negedge clk);
            if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'(1));
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = hold_v;
        if (hold_v) begin
            in_re = $urandom;
            in_im = $urandom;
        end
    endtask

    // Entered at the negedge of the first ISSUE cycle; bf_done is driven per lat/dur,
    // a level longer than one cycle spills into the following pair(s).
    task automatic pairs(input int rst_pair);
        bit done;
        for (int k = 0; k < 4; k++) begin
            bf_done = (carry > 0);
            if (carry > 0) carry--;
            chk("start", 64'(bf_start), 64'(1));
            chk("pair_idx", 64'(pair_idx), 64'(k));
            chk("x0", {bf_x0_re, bf_x0_im}, smp[rev3(2 * k)]);
            chk("x1", {bf_x1_re, bf_x1_im}, smp[rev3(2 * k + 1)]);
            chk("ready_busy", 64'({in_ready, busy}), 64'(1));
            if (use_tab) chk("table_re", {bf_x0_re, bf_x1_re}, {tab0[k], tab1[k]});
            done = 1'b0;
            for (int t = 1; t < 64 && !done; t++) begin
                @(negedge clk);
                if (hold_v) begin
                    in_re = $urandom;
                    in_im = $urandom;
                end
                if (carry > 0) begin
                    bf_done = 1'b1;
                    carry--;
                end else if (t == lat[k]) begin
                    bf_done = 1'b1;
                    carry = dur[k] - 1;
                end else begin
                    bf_done = 1'b0;
                end
                if (t == 1) chk("start_pulse", 64'({bf_start, in_ready}), 64'(0));
                if (k == rst_pair && t == 1) begin
                    #2 rst = 1'b1;
                    #1 chk("rst_ctl", 64'({in_ready, bf_start, busy, frame_done, pair_idx}), 64'(0));
                    chk("rst_x0", {bf_x0_re, bf_x0_im}, 64'(0));
                    chk("rst_x1", {bf_x1_re, bf_x1_im}, 64'(0));
                    @(negedge clk);
                    rst = 1'b0;
                    bf_done = 1'b0;
                    carry = 0;
                    in_valid = 1'b0;
                    return;
                end
                done = bf_done;
                if (done) begin
                    chk("x0_hold", {bf_x0_re, bf_x0_im}, smp[rev3(2 * k)]);
                    chk("x1_hold", {bf_x1_re, bf_x1_im}, smp[rev3(2 * k + 1)]);
                end
            end
            @(negedge clk);
        end
        bf_done = (carry > 0);
        chk("frame_done", 64'({frame_done, bf_start, busy}), 64'(3'b101));
        @(negedge clk);
        bf_done = 1'b0;
        carry = 0;
        in_valid = 1'b0;
        chk("back_to_fill", 64'({frame_done, in_ready, busy, pair_idx}), 64'(5'b01000));
        chk("ops_kept", {bf_x1_re, bf_x1_im}, smp[rev3(7)]);
    endtask

    initial begin
        #1 chk("reset_ctl", 64'({in_ready, bf_start, busy, frame_done, pair_idx}), 64'(0));
        chk("reset_ops", {bf_x0_re, bf_x1_im}, 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            smp[i].re = 32'(i + 1);
            smp[i].im = 32'(0);
        end
        lat = '{1, 1, 1, 1};
        dur = '{1, 1, 1, 1};
        tab0 = '{32'd1, 32'd3, 32'd2, 32'd4};
        tab1 = '{32'd5, 32'd7, 32'd6, 32'd8};
        use_tab = 1'b1;
        send(1'b0);
        pairs(-1);
        use_tab = 1'b0;

        for (int i = 0; i < 8; i++) begin
            smp[i].re = 32'(10 - i);
            smp[i].im = 32'(-i);
        end
        send(1'b0);
        pairs(-1);

        fill_rand();
        hold_v = 1'b1;
        lat = '{1, 5, 9, 2};
        dur = '{1, 1, 1, 3};
        send(1'b1);
        pairs(-1);

        fill_rand();
        lat = '{2, 3, 1, 4};
        dur = '{3, 1, 2, 1};
        send(1'b0);
        pairs(-1);
        hold_v = 1'b0;

        fill_rand();
        lat = '{2, 3, 2, 2};
        dur = '{1, 1, 1, 1};
        send(1'b0);
        pairs(1);
        fill_rand();
        send(1'b1);
        pairs(-1);

`ifdef FFT_LOADER_TIMEOUT_EN
        fill_rand();
        send(1'b0);
        for (int t = 0; t <= 16; t++) begin
            chk("timeout_no_done", 64'(frame_done), 64'(0));
            if (t == 16) chk("timeout_pre", 64'({timeout_err, busy}), 64'(2'b01));
            @(negedge clk);
        end
        chk("timeout_err", 64'({timeout_err, in_ready, busy}), 64'(3'b110));
        fill_rand();
        send(1'b0);
        pairs(-1);
        chk("timeout_sticky", 64'(timeout_err), 64'(1));
`endif

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            for (int k = 0; k < 4; k++) begin
                lat[k] = int'($urandom_range(1, 6));
                dur[k] = int'($urandom_range(1, 3));
            end
            hold_v = 1'($urandom_range(0, 1));
            send(1'($urandom_range(0, 1)));
            pairs(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
